// File: rtl/iterative_shifter.sv
// Multi-cycle 32-bit shifter: arithmetic right / logical left, one bit per clock.
// Define SHIFT_FAST_STEP_EN to advance four positions per clock while four or more remain.
module iterative_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             SH_DIR,
  input  logic [AMT_W-1:0] SH_AMT,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D_OUT,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] shifted;
  logic [AMT_W-1:0] step;

  // One shift step of the working register; right shifts replicate the sign bit.
  always_comb begin
    step    = AMT_W'(1);
    shifted = dir_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]}
                    : {work_q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_FAST_STEP_EN
    if (cnt_q >= AMT_W'(4)) begin
      step    = AMT_W'(4);
      shifted = dir_q ? {{4{work_q[WIDTH-1]}}, work_q[WIDTH-1:4]}
                      : {work_q[WIDTH-5:0], 4'b0000};
    end
`endif
  end

  // NOTE: every next-state signal takes its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          work_d = D_IN;
          cnt_d  = SH_AMT;
          dir_d  = SH_DIR;
          if (SH_AMT != '0) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
            dout_d  = D_IN;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - step;
        if (cnt_q == step) begin
          dout_d  = shifted;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign D_OUT = dout_q;
  assign Busy  = (state_q == S_SHIFT);
  assign Done  = (state_q == S_DONE);

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomised self-checking bench for iterative_shifter against a plain-arithmetic shift model.
module tb_iterative_shifter;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Start = 1'b0;
  logic             SH_DIR = 1'b0;
  logic [AMT_W-1:0] SH_AMT = '0;
  logic [WIDTH-1:0] D_IN = '0;
  logic [WIDTH-1:0] D_OUT;
  logic             Busy;
  logic             Done;

  int vectors = 0;
  int miscompares = 0;

  iterative_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .SH_DIR(SH_DIR),
    .SH_AMT(SH_AMT),
    .D_IN  (D_IN),
    .D_OUT (D_OUT),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic dir, input int amt, input logic [31:0] din);
    if (dir) return $unsigned($signed(din) >>> amt);
    else     return din << amt;
  endfunction

  function automatic int latency(input int amt);
`ifdef SHIFT_FAST_STEP_EN
    return amt / 4 + amt % 4;
`else
    return amt;
`endif
  endfunction

  // Presents a request and advances through its capture edge; inputs are then scrambled.
  task automatic launch(input logic dir, input int amt, input logic [31:0] din);
    Start  = 1'b1;
    SH_DIR = dir;
    SH_AMT = AMT_W'(amt);
    D_IN   = din;
    @(posedge Clk); #1;
    Start  = 1'b0;
    SH_DIR = 1'($urandom);
    SH_AMT = AMT_W'($urandom);
    D_IN   = $urandom;
  endtask

  // Waits for Done and checks latency, busy time and result; optionally pokes Start mid-shift.
  task automatic wait_done(input string tag, input logic dir, input int amt,
                           input logic [31:0] din, input int poke_at);
    int k = 0;
    int busy_cycles = 0;
    while (!Done && k < 64) begin
      busy_cycles += int'(Busy);
      if (k == poke_at) begin
        Start = 1'b1; SH_DIR = 1'b0; SH_AMT = AMT_W'(5); D_IN = 32'h1234_5678;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      k++;
    end
    Start = 1'b0;
    check({tag, "_done"},    32'(Done), 32'd1);
    check({tag, "_latency"}, k, latency(amt));
    check({tag, "_busy"},    busy_cycles, latency(amt));
    check({tag, "_dout"},    D_OUT, model(dir, amt, din));
  endtask

  task automatic run_op(input string tag, input logic dir, input int amt, input logic [31:0] din);
    launch(dir, amt, din);
    wait_done(tag, dir, amt, din, -1);
    @(posedge Clk); #1;
    check({tag, "_pulse"}, 32'(Done), 32'd0);
    check({tag, "_hold"},  D_OUT, model(dir, amt, din));
  endtask

  initial begin
    #1;
    check("rst_dout", D_OUT, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1;

    for (int a = 0; a < 32; a++) run_op("sra_sweep", 1'b1, a, 32'h8000_0000);
    for (int a = 0; a < 32; a++) run_op("sll_sweep", 1'b0, a, 32'h0000_0001);
    run_op("sra_30", 1'b1, 30, 32'h4000_0000);
    run_op("sra_31", 1'b1, 31, 32'h4000_0000);
    run_op("zero_amt", 1'b0, 0, 32'hDEAD_BEEF);

    // Start during SHIFT is ignored; the original result arrives on time.
    launch(1'b1, 10, 32'hF0F0_0F0F);
    wait_done("ignore", 1'b1, 10, 32'hF0F0_0F0F, 2);

    // Start held through the DONE cycle launches the next op without a gap.
    launch(1'b0, 7, 32'hA5A5_5A5A);
    wait_done("b2b_a", 1'b0, 7, 32'hA5A5_5A5A, -1);
    launch(1'b1, 9, 32'h8765_4321);
    wait_done("b2b_b", 1'b1, 9, 32'h8765_4321, -1);
    @(posedge Clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic        d;
      int          a;
      logic [31:0] x;
      d = 1'($urandom);
      a = int'($urandom_range(31, 0));
      x = $urandom;
      run_op("rand", d, a, x);
    end

    // Asynchronous reset mid-shift clears everything at once.
    launch(1'b1, 20, 32'h8000_0000);
    repeat (5) @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("midrst_dout", D_OUT, 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1;
    run_op("post_rst", 1'b1, 20, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
